// File: rtl/card_pkg.sv
// card_pkg: shared card-store constants, opcodes and FSM state type
package card_pkg;
  localparam int CARD_W     = 6;
  localparam int EMPTY_CARD = 63;
  localparam int CARD_MOD   = 55;
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_WRITE    = 3'd1;
  localparam logic [2:0] OP_SHIFT_IN = 3'd2;
  localparam logic [2:0] OP_TOGGLE   = 3'd3;
  localparam logic [2:0] OP_INVERT   = 3'd4;
  localparam logic [2:0] OP_CLEAR    = 3'd5;
  localparam logic [2:0] OP_INIT     = 3'd6;
  localparam logic [2:0] OP_UNDO     = 3'd7;
  typedef enum logic {S_IDLE, S_INIT} state_t;
endpackage

// File: rtl/card_popcount.sv
// card_popcount: combinational count of slots whose code differs from EMPTY_CARD
//   map_flat in  N_SLOTS*CARD_W  packed slot codes
//   cnt      out $clog2(N_SLOTS)+1  number of non-empty slots
module card_popcount
  import card_pkg::*;
#(
  parameter int N_SLOTS    = 144,
  parameter int CARD_W     = card_pkg::CARD_W,
  parameter int EMPTY_CARD = card_pkg::EMPTY_CARD
) (
  input  logic [N_SLOTS*CARD_W-1:0]  map_flat,
  output logic [$clog2(N_SLOTS):0]   cnt
);
  localparam int CNT_W = $clog2(N_SLOTS) + 1;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_SLOTS; i++)
      cnt = cnt + CNT_W'(map_flat[i*CARD_W +: CARD_W] != CARD_W'(EMPTY_CARD));
  end
endmodule

// File: rtl/card_map_bank.sv
// card_map_bank: card-slot store (codes + select bits) with command port and display read port
//   clk, rst (sync, active-high)
//   cmd_valid/cmd_ready/cmd_op/cmd_slot/cmd_card  command port; cmd_err pulses on a rejected command
//   rd_slot -> rd_card/rd_sel                     1-cycle-latency read, sees pre-command state
//   map_flat, sel_flat, nonempty_cnt, busy        display buses and status
//   Optional macro CARD_MAP_UNDO_EN adds a one-deep undo snapshot for opcode 7.
module card_map_bank #(
  parameter int N_SLOTS    = 144,
  parameter int CARD_W     = card_pkg::CARD_W,
  parameter int CARD_MOD   = card_pkg::CARD_MOD,
  parameter int EMPTY_CARD = card_pkg::EMPTY_CARD,
  localparam int SLOT_W    = $clog2(N_SLOTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [SLOT_W-1:0]          cmd_slot,
  input  logic [CARD_W-1:0]          cmd_card,
  output logic                       cmd_err,
  input  logic [SLOT_W-1:0]          rd_slot,
  output logic [CARD_W-1:0]          rd_card,
  output logic                       rd_sel,
  output logic [N_SLOTS*CARD_W-1:0]  map_flat,
  output logic [N_SLOTS-1:0]         sel_flat,
  output logic [SLOT_W:0]            nonempty_cnt,
  output logic                       busy
);
  import card_pkg::*;
  // extended by one bit so the range check also works when N_SLOTS is a power of two
  localparam logic [SLOT_W:0] N_EXT = (SLOT_W+1)'(N_SLOTS);
  state_t state, state_nx;
  logic [CARD_W-1:0] map [N_SLOTS];
  logic [N_SLOTS-1:0] sel;
  logic [SLOT_W-1:0] idx;
  logic [SLOT_W:0] pop_cnt;
  logic fire, last, rd_ok, slot_bad, bad;
  assign fire     = cmd_valid & cmd_ready;
  assign last     = idx == SLOT_W'(N_SLOTS - 1);
  assign rd_ok    = {1'b0, rd_slot} < N_EXT;
  assign slot_bad = (cmd_op == OP_WRITE || cmd_op == OP_TOGGLE) && {1'b0, cmd_slot} >= N_EXT;
  assign sel_flat = sel;
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_flat
    assign map_flat[i*CARD_W +: CARD_W] = map[i];
  end
`ifdef CARD_MAP_UNDO_EN
  logic [CARD_W-1:0] snap_map [N_SLOTS];
  logic [N_SLOTS-1:0] snap_sel;
  logic snap_valid;
  assign bad = slot_bad || (cmd_op == OP_UNDO && !snap_valid);
  always_ff @(posedge clk) begin
    if (rst || (state == S_INIT && last))
      snap_valid <= 1'b0;
    else if (fire && !bad && cmd_op != OP_NOP)
      snap_valid <= cmd_op != OP_UNDO;
  end
  always_ff @(posedge clk) begin
    if (fire && !bad && cmd_op != OP_NOP && cmd_op != OP_UNDO) begin
      for (int i = 0; i < N_SLOTS; i++) snap_map[i] <= map[i];
      snap_sel <= sel;
    end
  end
`else
  assign bad = slot_bad;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_INIT ? (last ? S_IDLE : S_INIT)
                               : (fire && cmd_op == OP_INIT ? S_INIT : S_IDLE);
  end
  always_comb begin
    busy      = state == S_INIT;
    cmd_ready = state == S_IDLE;
  end
  card_popcount #(.N_SLOTS(N_SLOTS), .CARD_W(CARD_W), .EMPTY_CARD(EMPTY_CARD)) u_pop (
    .map_flat (map_flat),
    .cnt      (pop_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) map[i] <= '0;
      sel          <= '0;
      idx          <= '0;
      rd_card      <= '0;
      rd_sel       <= 1'b0;
      cmd_err      <= 1'b0;
      nonempty_cnt <= '0;
    end else begin
      rd_card      <= rd_ok ? map[rd_slot] : '0;
      rd_sel       <= rd_ok ? sel[rd_slot] : 1'b0;
      nonempty_cnt <= pop_cnt;
      cmd_err      <= fire & bad;
      if (state == S_INIT) begin
        map[idx] <= CARD_W'(idx % CARD_MOD);
        sel[idx] <= 1'b0;
        idx      <= last ? '0 : idx + 1'b1;
      end else if (fire && !bad) begin
        case (cmd_op)
          OP_WRITE:  map[cmd_slot] <= cmd_card;
          OP_SHIFT_IN: begin
            for (int i = 0; i < N_SLOTS - 1; i++) map[i] <= map[i+1];
            map[N_SLOTS-1] <= cmd_card;
            sel            <= {1'b0, sel[N_SLOTS-1:1]};
          end
          OP_TOGGLE: sel[cmd_slot] <= ~sel[cmd_slot];
          OP_INVERT: sel <= ~sel;
          OP_CLEAR:  sel <= '0;
          OP_INIT:   idx <= '0;
`ifdef CARD_MAP_UNDO_EN
          OP_UNDO: begin
            for (int i = 0; i < N_SLOTS; i++) map[i] <= snap_map[i];
            sel <= snap_sel;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule
